// File: rtl/jk_excitation_driver.sv
// Drives a negative-edge JK flop to a requested Q using the excitation table, with an internally generated slow flop clock.
// Latency: accept-to-done is at most 3*TICK_DIV+SETTLE_CYC+2 cycles; J/K/jk_clk/done/err are registered.
// Backpressure: req_ready is high only in IDLE (and never on the cycle jk_clk is about to fall); requests while busy are dropped.
module jk_excitation_driver #(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic        DC_FILL    = 1'b0,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk_50MHz,
  input  logic             nReset,
  input  logic             req_valid,
  input  logic             req_q,
  output logic             req_ready,
  output logic             jk_clk,
  output logic             J,
  output logic             K,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_FIRE   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jk_clk_q, jk_clk_d;
  logic [1:0]       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic wrap;
  logic rise_evt;
  logic fall_evt;

  // Excitation table: {J,K} that moves the flop from cur to tgt.
  function automatic logic [1:0] excite(input logic cur, input logic tgt);
    logic [1:0] jk;
    case ({cur, tgt})
      2'b00:   jk = {1'b0, DC_FILL};
      2'b01:   jk = {1'b1, DC_FILL};
      2'b10:   jk = {DC_FILL, 1'b1};
      default: jk = {DC_FILL, 1'b0};
    endcase
    return jk;
  endfunction

  assign wrap     = (cnt_q == CNT_LAST);
  assign rise_evt = wrap & ~jk_clk_q;
  assign fall_evt = wrap & jk_clk_q;

  // Accepting on a fall_evt cycle would move J/K on the very edge the flop samples, so hold off that one cycle.
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = nReset & (state_q == ST_IDLE) & ~fall_evt;

  assign jk_clk    = jk_clk_q;
  assign J         = j_q;
  assign K         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;

  // Free-running divider: jk_clk toggles every TICK_DIV cycles, regardless of the FSM.
  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    jk_clk_d = jk_clk_q ^ wrap;
  end

  // Request FSM: capture target, hold J/K across one full rise->fall of jk_clk, then check Q after settling.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    j_d         = j_q;
    k_d         = k_q;
    settle_d    = settle_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (req_valid && req_ready) begin
          tgt_d      = req_q;
          {j_d, k_d} = excite(q_fb, req_q);
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        // Waiting for a rise after the accept cycle keeps J/K stable for a whole high phase before the fall.
        if (rise_evt) begin
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (fall_evt) begin
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - SET_W'(1);
        if (settle_q == SET_W'(1)) begin
          done_d  = 1'b1;
          err_d   = q_fb ^ tgt_q;
          if (err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any operation without a done pulse.
  always_ff @(posedge clk_50MHz) begin
    if (!nReset) begin
      cnt_q       <= '0;
      jk_clk_q    <= 1'b0;
      state_q     <= ST_IDLE;
      tgt_q       <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      settle_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      jk_clk_q    <= jk_clk_d;
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (DC_FILL=0 and 1) share stimulus, each driving its own JK flop model.
// A schedule-based model predicts every output each cycle; directed literals pin the model.
module tb_jk_excitation_driver;

  localparam int TD      = 4;
  localparam int SC      = 2;
  localparam int LAT_MAX = 3*TD + SC + 2;

  logic clk_50MHz = 1'b0;
  logic nReset, req_valid, req_q, fault;

  logic ready0, jkc0, j0, k0, busy0, done0, err0, qfb0, flq0;
  logic ready1, jkc1, j1, k1, busy1, done1, err1, qfb1, flq1;
  logic [7:0] errc0, errc1;

  logic [1:0] ready_a, jkc_a, j_a, k_a, busy_a, done_a, err_a, qfb_a;
  logic [7:0] errc_a [2];

  always #5 clk_50MHz = ~clk_50MHz;

  jk_excitation_driver #(.TICK_DIV(TD), .SETTLE_CYC(SC), .DC_FILL(1'b0), .ERR_W(8)) u_dut0 (
    .clk_50MHz(clk_50MHz), .nReset(nReset), .req_valid(req_valid), .req_q(req_q),
    .req_ready(ready0), .jk_clk(jkc0), .J(j0), .K(k0), .q_fb(qfb0),
    .busy(busy0), .done(done0), .err(err0), .err_count(errc0));

  jk_excitation_driver #(.TICK_DIV(TD), .SETTLE_CYC(SC), .DC_FILL(1'b1), .ERR_W(8)) u_dut1 (
    .clk_50MHz(clk_50MHz), .nReset(nReset), .req_valid(req_valid), .req_q(req_q),
    .req_ready(ready1), .jk_clk(jkc1), .J(j1), .K(k1), .q_fb(qfb1),
    .busy(busy1), .done(done1), .err(err1), .err_count(errc1));

  assign qfb0 = fault ? 1'b0 : flq0;
  assign qfb1 = flq1;

  assign ready_a = {ready1, ready0};
  assign jkc_a   = {jkc1, jkc0};
  assign j_a     = {j1, j0};
  assign k_a     = {k1, k0};
  assign busy_a  = {busy1, busy0};
  assign done_a  = {done1, done0};
  assign err_a   = {err1, err0};
  assign qfb_a   = {qfb1, qfb0};
  assign errc_a[0] = errc0;
  assign errc_a[1] = errc1;

  // JK flop models on the falling edge of the slow clock
  always @(negedge jkc0 or negedge nReset)
    if (!nReset) flq0 <= 1'b0;
    else         flq0 <= (j0 & ~flq0) | (~k0 & flq0);

  always @(negedge jkc1 or negedge nReset)
    if (!nReset) flq1 <= 1'b0;
    else         flq1 <= (j1 & ~flq1) | (~k1 & flq1);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] excite(input logic cur, input logic tgt, input logic fill);
    case ({cur, tgt})
      2'b00:   return {1'b0, fill};
      2'b01:   return {1'b1, fill};
      2'b10:   return {fill, 1'b1};
      default: return {fill, 1'b0};
    endcase
  endfunction

  // First cycle index r > p at which the slow clock is low at the end of its phase (a rising wrap)
  function automatic int next_rise(input int p);
    return p + 1 + (((TD - 1) - ((p + 1) % (2*TD)) + 2*TD) % (2*TD));
  endfunction

  // Model state
  bit   m_on = 1'b0;
  bit   m_acc_now = 1'b0;
  bit   chk_high_stable = 1'b0;
  bit   prev_run = 1'b0;
  int   k_cyc = 0;
  logic m_busy [2], m_j [2], m_k [2], m_done [2], m_err [2], m_tgt [2];
  int   m_errc [2], m_dpre [2], m_acc [2];
  int   done_cnt [2] = '{0, 0};
  int   acc_cnt [2] = '{0, 0};
  logic last_err [2];
  logic p_jkc [2], p_j [2], p_k [2], p_busy [2];

  // Model step and compare, once per cycle on the falling edge of the system clock
  always @(negedge clk_50MHz) begin
    int p;
    logic [1:0] jk;
    cyc++;
    m_acc_now = 1'b0;
    if (!nReset) begin
      m_on  = 1'b1;
      k_cyc = 0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b0; m_j[d] = 1'b0; m_k[d] = 1'b0;
        m_done[d] = 1'b0; m_err[d] = 1'b0; m_errc[d] = 0;
      end
    end else if (m_on) begin
      p = k_cyc;
      k_cyc++;
      for (int d = 0; d < 2; d++) begin
        m_done[d] = 1'b0;
        m_err[d]  = 1'b0;
        if (m_busy[d] && p == m_dpre[d]) begin
          m_done[d] = 1'b1;
          m_err[d]  = (qfb_a[d] != m_tgt[d]);
          if (m_err[d] && m_errc[d] < 255) m_errc[d]++;
          m_busy[d] = 1'b0; m_j[d] = 1'b0; m_k[d] = 1'b0;
        end else if (!m_busy[d] && req_valid && (p % (2*TD)) != 2*TD - 1) begin
          m_tgt[d]  = req_q;
          jk        = excite(qfb_a[d], req_q, (d == 1));
          m_j[d]    = jk[1];
          m_k[d]    = jk[0];
          m_busy[d] = 1'b1;
          m_dpre[d] = next_rise(p) + TD + SC;
          m_acc[d]  = p;
          m_acc_now = 1'b1;
        end
      end
    end
    if (m_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("jk_clk%0d", d), jkc_a[d], (k_cyc / TD) % 2);
        check($sformatf("J%0d", d), j_a[d], m_j[d]);
        check($sformatf("K%0d", d), k_a[d], m_k[d]);
        check($sformatf("done%0d", d), done_a[d], m_done[d]);
        check($sformatf("busy%0d", d), busy_a[d], m_busy[d]);
        check($sformatf("err_count%0d", d), errc_a[d], m_errc[d]);
        check($sformatf("req_ready%0d", d), ready_a[d],
              (nReset && !m_busy[d] && (k_cyc % (2*TD)) != 2*TD - 1) ? 1 : 0);
        if (m_done[d]) check($sformatf("err%0d", d), err_a[d], m_err[d]);
        if (done_a[d]) begin
          done_cnt[d]++;
          last_err[d] = err_a[d];
          check($sformatf("latency_le_%0d_dut%0d", LAT_MAX, d), (k_cyc - m_acc[d] <= LAT_MAX) ? 1 : 0, 1);
        end
        if (nReset && prev_run) begin
          if (!p_busy[d] && busy_a[d]) acc_cnt[d]++;
          if (p_jkc[d] && !jkc_a[d])
            check($sformatf("jk_change_at_fall%0d", d), (j_a[d] != p_j[d] || k_a[d] != p_k[d]) ? 1 : 0, 0);
          if (chk_high_stable && p_jkc[d] && jkc_a[d])
            check($sformatf("jk_change_while_high%0d", d), (j_a[d] != p_j[d] || k_a[d] != p_k[d]) ? 1 : 0, 0);
        end
        p_jkc[d] = jkc_a[d]; p_j[d] = j_a[d]; p_k[d] = k_a[d]; p_busy[d] = busy_a[d];
      end
    end
    prev_run = nReset;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk_50MHz);
      #1;
    end
  endtask

  // Raise a request until the handshake completes, then drop it
  task automatic issue(input logic q);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_q     = q;
    do begin
      wait_cyc(1);
      n++;
    end while (!m_acc_now && n < 40);
    req_valid = 1'b0;
    check("accept_within_bound", (n < 40) ? 1 : 0, 1);
  endtask

  task automatic wait_done();
    int n;
    int c0;
    n  = 0;
    c0 = done_cnt[0];
    while (done_cnt[0] == c0 && n < 40) begin
      wait_cyc(1);
      n++;
    end
    check("done_within_bound", (n < 40) ? 1 : 0, 1);
  endtask

  initial begin
    int a0, d0, n, dc;
    bit seen_low;
    nReset = 1'b1; req_valid = 1'b0; req_q = 1'b0; fault = 1'b0;
    #1 nReset = 1'b0;
    wait_cyc(3);

    // Reset state
    check("rst_jk_clk", jkc0, 0);
    check("rst_J", j0, 0);
    check("rst_K", k0, 0);
    check("rst_done", done0, 0);
    check("rst_err_count", errc0, 0);
    check("rst_req_ready0", ready0, 0);
    check("rst_req_ready1", ready1, 0);
    nReset = 1'b1;
    wait_cyc(1);
    check("ready_after_release", ready0, 1);

    // Set the flop: 0->1
    issue(1'b1);
    check("set_J0", j0, 1);   check("set_K0", k0, 0);
    check("set_J1", j1, 1);   check("set_K1", k1, 1);
    wait_done();
    check("set_err0", last_err[0], 0);
    check("set_q0", flq0, 1);
    check("set_q1", flq1, 1);

    // Reset the flop: 1->0
    issue(1'b0);
    check("clr_J0", j0, 0);   check("clr_K0", k0, 1);
    check("clr_J1", j1, 1);   check("clr_K1", k1, 1);
    wait_done();
    check("clr_err0", last_err[0], 0);
    check("clr_q0", flq0, 0);
    check("clr_q1", flq1, 0);

    // Hold at 0: 0->0
    issue(1'b0);
    check("hold_J0", j0, 0);  check("hold_K0", k0, 0);
    check("hold_J1", j1, 0);  check("hold_K1", k1, 1);
    wait_done();
    check("hold_err1", last_err[1], 0);
    check("hold_q1", flq1, 0);

    // Feedback stuck at 0: mismatch, then saturate the counter
    fault = 1'b1;
    issue(1'b1);
    wait_done();
    check("fault_err", last_err[0], 1);
    check("fault_err_count", errc0, 1);
    for (int i = 0; i < 300; i++) begin
      issue(1'b1);
      wait_done();
    end
    check("sat_err_count0", errc0, 255);
    check("sat_err_count1", errc1, 0);
    fault = 1'b0;

    // Continuous request: one accept per done, J/K quiet while jk_clk is high
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    req_valid = 1'b1;
    n = 0;
    do begin
      wait_cyc(1);
      n++;
    end while (!m_acc_now && n < 40);
    check("cont_first_accept", (n < 40) ? 1 : 0, 1);
    chk_high_stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      req_q = ~req_q;
      wait_cyc(1);
    end
    req_valid = 1'b0;
    wait_cyc(30);
    chk_high_stable = 1'b0;
    check("cont_accepts_eq_dones", acc_cnt[0] - a0, done_cnt[0] - d0);
    check("cont_several_ops", (done_cnt[0] - d0 >= 5) ? 1 : 0, 1);

    // Reset while the flop clock is in its high phase of the operation
    issue(1'b1);
    n = 0;
    seen_low = 1'b0;
    while (!(seen_low && jkc0) && n < 40) begin
      if (!jkc0) seen_low = 1'b1;
      wait_cyc(1);
      n++;
    end
    check("reach_fire", (n < 40) ? 1 : 0, 1);
    check("fire_busy", busy0, 1);
    dc = done_cnt[0];
    nReset = 1'b0;
    wait_cyc(1);
    check("abort_J", j0, 0);
    check("abort_K", k0, 0);
    check("abort_jk_clk", jkc0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_err_count", errc0, 0);
    nReset = 1'b1;
    wait_cyc(30);
    check("abort_no_done", done_cnt[0], dc);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives a negative-edge JK flip-flop toward a requested next state.
- Accepts a target Q value through a valid/ready handshake and computes J/K from the excitation table using the flop's current Q.
- Generates the flop's slow clock internally, then reads Q back after the falling edge and reports done or mismatch.
- Sits between a control or test sequencer and a JK_FF instance; one clock domain.

Parameters:
- TICK_DIV, 25_000_000: clk_50MHz cycles per half-period of jk_clk. Legal range is 2 and above.
- SETTLE_CYC, 2: cycles to wait after the jk_clk falling edge before sampling q_fb. Legal range is 1 and above.
- DC_FILL, 0: value driven on the don't-care J or K input of the excitation table.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk_50MHz  in  1  system clock; all logic is on its posedge
- nReset  in  1  synchronous, active-low reset
- req_valid  in  1  request strobe
- req_q  in  1  target next value of Q
- req_ready  out  1  high only in IDLE
- jk_clk  out  1  slow clock to the flop's Clk input
- J  out  1  to flop J
- K  out  1  to flop K
- q_fb  in  1  flop Q readback
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 means q_fb differs from the target
- err_count  out  ERR_W  saturating count of mismatches

Behaviour:
- Reset: when nReset=0 at a posedge, the block goes to this state:
  - divider count=0, jk_clk=0, state=IDLE
  - J=0, K=0, done=0, err=0, err_count=0
  - req_ready=0 while nReset is low
- Reset applied in any state aborts the operation. No done pulse is produced for an aborted operation.
- Divider runs free, independent of the FSM:
  - count runs 0..TICK_DIV-1 and wraps.
  - jk_clk toggles on each wrap, so its period is 2*TICK_DIV cycles.
  - rise_evt = wrap while jk_clk=0.
  - fall_evt = wrap while jk_clk=1.
- FSM states: IDLE, ARM, FIRE, SETTLE.
- IDLE:
  - J=K=0, so any jk_clk fall holds the flop.
  - On req_valid & req_ready: capture tgt=req_q and cur=q_fb, register J/K, go to ARM. J/K become valid on the next cycle.
- Excitation table (cur->tgt gives J,K):
  - 0->0: 0, DC_FILL
  - 0->1: 1, DC_FILL
  - 1->0: DC_FILL, 1
  - 1->1: DC_FILL, 0
- ARM: wait for rise_evt, then go to FIRE. This guarantees J/K are stable for at least TICK_DIV cycles before the falling edge.
- FIRE: J/K held; wait for fall_evt. On fall_evt, load the settle counter with SETTLE_CYC and go to SETTLE.
- SETTLE:
  - Decrement the settle counter each cycle.
  - On the cycle it reaches 0: done=1, err=(q_fb!=tgt).
  - If err=1, err_count increments, saturating at 2^ERR_W-1.
  - J=K=0 and state=IDLE on the next cycle.
- req_valid while busy is ignored; no queueing.
- A request accepted on the same cycle as a rise_evt still waits for the next rise_evt. J/K are never changed on the edge the flop uses.
- Latency from accept to done is bounded by 3*TICK_DIV+SETTLE_CYC+2 cycles.
- The block has no combinational path from inputs to J/K/jk_clk; all outputs are registered, except req_ready/busy, which are decoded from state.

Test Plan:
- Common bench setup: TICK_DIV=4, SETTLE_CYC=2, JK_FF model clocked by jk_clk, flop reset to Q=0.
- Reset: hold nReset=0 for 3 cycles -> jk_clk=0, J=K=0, done=0, err_count=0, req_ready=0; req_ready=1 on the first cycle after release.
- Set, then reset the flop: with q=0, request req_q=1 -> J=1,K=0 held through a jk_clk fall, done pulse with err=0, q_fb=1. Then request req_q=0 -> J=0,K=1, done with err=0, q_fb=0.
- Hold with DC_FILL=1 build: with q=0, request req_q=0 -> J=0,K=1, q_fb stays 0, done with err=0. With DC_FILL=0 the same request gives J=0,K=0.
- Fault and saturation, with q_fb tied 0:
  - Request req_q=1 -> done with err=1, err_count=1.
  - Issue 300 such requests -> err_count stops at 255.
- Busy and timing:
  - Assert req_valid continuously -> exactly one accept per completed done, req_ready=0 during ARM/FIRE/SETTLE.
  - Accept-to-done is at most 16 cycles.
  - J/K never change while jk_clk=1.
- Mid-operation reset: assert nReset=0 during FIRE -> next cycle J=K=0, jk_clk=0, IDLE; no done pulse; err_count cleared.
